// File: rtl/data_mem_arbiter.sv
// Two-requester data-memory arbiter with round-robin priority.
// One access at a time: IDLE -> ACCESS -> DONE, or IDLE -> DONE on a rejected access.
module data_mem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              reset_n,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              done0_o,
  output logic              done1_o,
  output logic              err0_o,
  output logic              err1_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [31:0]       mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_write_o,
  output logic              mem_read_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_WORD =
    ADDR_W'((2 ** ADDR_W) - 4);

  state_t              state_q, state_d;
  logic                prio_q;
  logic                id_q;
  logic                we_q;
  logic                err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                any_req;
  logic                sel1;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                legal;
  logic                take;

  // Pick the winner: a lone requester wins, otherwise prio decides.
  always_comb begin
    any_req   = req0_i | req1_i;
    sel1      = req1_i & (~req0_i | prio_q);
    sel_we    = sel1 ? we1_i    : we0_i;
    sel_addr  = sel1 ? addr1_i  : addr0_i;
    sel_wdata = sel1 ? wdata1_i : wdata0_i;
    legal     = (sel_addr[1:0] == 2'b00) &&
                (sel_addr <= LAST_WORD);
    take      = (state_q == IDLE) & any_req & reset_n;
  end

  // Next state and all outputs, decoded from the current state.
  always_comb begin
    state_d     = state_q;
    gnt0_o      = 1'b0;
    gnt1_o      = 1'b0;
    done0_o     = 1'b0;
    done1_o     = 1'b0;
    err0_o      = 1'b0;
    err1_o      = 1'b0;
    rdata_o     = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_write_o = 1'b0;
    mem_read_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          state_d = legal ? ACCESS : DONE;
          gnt0_o  = ~sel1;
          gnt1_o  = sel1;
        end
      end
      ACCESS: begin
        state_d     = DONE;
        mem_addr_o  = 32'(addr_q);
        mem_wdata_o = wdata_q;
        mem_write_o = we_q;
        mem_read_o  = ~we_q;
      end
      DONE: begin
        state_d = IDLE;
        done0_o = ~id_q;
        done1_o = id_q;
        err0_o  = ~id_q & err_q;
        err1_o  = id_q & err_q;
        if (!err_q && !we_q) rdata_o = rdata_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, priority pointer, request latches and read-data register.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        id_q    <= sel1;
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        err_q   <= ~legal;
      end
      if (state_q == ACCESS && !we_q) rdata_q <= mem_rdata_i;
      if (state_q == DONE) prio_q <= ~id_q;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations on logged events.
module tb_data_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_i = 0, req1_i = 0, we0_i = 0, we1_i = 0;
  logic [4:0]  addr0_i = 0, addr1_i = 0;
  logic [31:0] wdata0_i = 0, wdata1_i = 0;
  logic        gnt0_o, gnt1_o, done0_o, done1_o, err0_o, err1_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        mem_write_o, mem_read_o;

  int total = 0;
  int bad = 0;

  data_mem_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk_i(clk_i), .reset_n(reset_n),
    .req0_i(req0_i), .req1_i(req1_i),
    .we0_i(we0_i), .we1_i(we1_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i),
    .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .gnt0_o(gnt0_o), .gnt1_o(gnt1_o),
    .done0_o(done0_o), .done1_o(done1_o),
    .err0_o(err0_o), .err1_o(err1_o),
    .rdata_o(rdata_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_write_o(mem_write_o),
    .mem_read_o(mem_read_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // memory attached to the arbiter
  logic [31:0] tbmem [8] = '{default: 32'h0};
  assign mem_rdata_i = tbmem[mem_addr_o[4:2]];
  always @(posedge clk_i)
    if (mem_write_o) tbmem[mem_addr_o[4:2]] <= mem_wdata_o;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, 32'(act), 32'(exp));
  endtask

  // transaction model state
  int          cyc = 0;
  bit          pend = 0;
  bit          p_id, p_we, p_legal;
  logic [4:0]  p_addr;
  logic [31:0] p_wd;
  int          p_gc;
  int          free_at = 0;
  bit          m_prio = 0;
  logic [31:0] refmem [8] = '{default: 32'h0};

  logic        e_g0, e_g1, e_d0, e_d1, e_e0, e_e1, e_w, e_r;
  logic [31:0] e_a, e_wd, e_rd;
  bit          w1;

  // observed event logs for directed literal checks
  int          g_cyc[$];
  int          g_id[$];
  int          d_cyc[$];
  int          d_id[$];
  bit          d_err[$];
  logic [31:0] d_rd[$];
  int          s_cyc[$];
  logic [31:0] s_addr[$];
  bit          s_wr[$];

  task automatic clear_logs();
    g_cyc.delete(); g_id.delete();
    d_cyc.delete(); d_id.delete(); d_err.delete(); d_rd.delete();
    s_cyc.delete(); s_addr.delete(); s_wr.delete();
  endtask

  // model + compare, every cycle at the falling edge
  always @(negedge clk_i) begin
    e_g0 = 0; e_g1 = 0; e_d0 = 0; e_d1 = 0; e_e0 = 0; e_e1 = 0;
    e_w = 0; e_r = 0; e_a = 0; e_wd = 0; e_rd = 0;
    if (!reset_n) begin
      pend = 0;
      m_prio = 0;
      free_at = cyc + 1;
    end else begin
      if (pend && p_legal && cyc == p_gc + 1) begin
        e_w = p_we; e_r = !p_we;
        e_a = 32'(p_addr); e_wd = p_wd;
        if (p_we) refmem[p_addr[4:2]] = p_wd;
      end
      if (pend && cyc == p_gc + (p_legal ? 2 : 1)) begin
        e_d0 = !p_id; e_d1 = p_id;
        e_e0 = !p_id && !p_legal; e_e1 = p_id && !p_legal;
        e_rd = (p_legal && !p_we) ? refmem[p_addr[4:2]] : 32'h0;
        m_prio = !p_id;
        pend = 0;
        free_at = cyc + 1;
      end else if (!pend && cyc >= free_at && (req0_i || req1_i)) begin
        w1 = req1_i && (!req0_i || m_prio);
        p_id = w1;
        p_we = w1 ? we1_i : we0_i;
        p_addr = w1 ? addr1_i : addr0_i;
        p_wd = w1 ? wdata1_i : wdata0_i;
        p_legal = (p_addr % 4 == 0) && (int'(p_addr) <= 28);
        p_gc = cyc;
        pend = 1;
        e_g0 = !w1; e_g1 = w1;
      end
    end
    chk1("gnt0", gnt0_o, e_g0);
    chk1("gnt1", gnt1_o, e_g1);
    chk1("done0", done0_o, e_d0);
    chk1("done1", done1_o, e_d1);
    chk1("err0", err0_o, e_e0);
    chk1("err1", err1_o, e_e1);
    chk1("mem_write", mem_write_o, e_w);
    chk1("mem_read", mem_read_o, e_r);
    chk("mem_addr", mem_addr_o, e_a);
    chk("mem_wdata", mem_wdata_o, e_wd);
    chk("rdata", rdata_o, e_rd);
    if (gnt0_o) begin g_cyc.push_back(cyc); g_id.push_back(0); end
    if (gnt1_o) begin g_cyc.push_back(cyc); g_id.push_back(1); end
    if (done0_o || done1_o) begin
      d_cyc.push_back(cyc);
      d_id.push_back(done1_o ? 1 : 0);
      d_err.push_back(err0_o | err1_o);
      d_rd.push_back(rdata_o);
    end
    if (mem_write_o || mem_read_o) begin
      s_cyc.push_back(cyc);
      s_addr.push_back(mem_addr_o);
      s_wr.push_back(mem_write_o);
    end
    cyc++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic do_req(input int p, input bit we, input logic [4:0] a,
                        input logic [31:0] wd);
    bit got;
    got = 0;
    if (p == 0) begin
      req0_i = 1; we0_i = we; addr0_i = a; wdata0_i = wd;
    end else begin
      req1_i = 1; we1_i = we; addr1_i = a; wdata1_i = wd;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_i);
      got = (p == 0) ? gnt0_o : gnt1_o;
    end
    chk1("req_grant_seen", got, 1'b1);
    @(posedge clk_i);
    #1;
    if (p == 0) req0_i = 0;
    else req1_i = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    // reset: gnt must stay low even with a request present
    idle(1);
    req0_i = 1;
    #1;
    chk1("rst_gnt0", gnt0_o, 1'b0);
    chk1("rst_mem_read", mem_read_o, 1'b0);
    idle(2);
    req0_i = 0;
    reset_n = 1;
    idle(2);

    // write 8 then read it back
    clear_logs();
    do_req(0, 1, 5'd8, 32'hDEADBEEF);
    idle(3);
    do_req(0, 0, 5'd8, 32'h12345678);
    idle(3);
    chk("wr_ngnt", 32'(g_cyc.size()), 32'd2);
    if (g_cyc.size() == 2 && d_cyc.size() == 2 && s_cyc.size() == 2) begin
      chk("wr_strobe_lat", 32'(s_cyc[0] - g_cyc[0]), 32'd1);
      chk("wr_done_lat", 32'(d_cyc[0] - g_cyc[0]), 32'd2);
      chk1("wr_strobe_is_write", s_wr[0], 1'b1);
      chk("wr_strobe_addr", s_addr[0], 32'd8);
      chk("rd_rdata", d_rd[1], 32'hDEADBEEF);
      chk1("rd_err", d_err[1], 1'b0);
    end else chk("wr_rd_events", 32'(d_cyc.size()), 32'd2);

    // fresh reset, then simultaneous reads
    reset_n = 0;
    idle(2);
    reset_n = 1;
    clear_logs();
    for (int r = 0; r < 2; r++) begin
      fork
        do_req(0, 0, 5'd0, 32'h1);
        do_req(1, 0, 5'd4, 32'h2);
      join
      idle(3);
    end
    if (g_id.size() == 4) begin
      chk("sim_w0", 32'(g_id[0]), 32'd0);
      chk("sim_w1", 32'(g_id[1]), 32'd1);
      chk("sim_w2", 32'(g_id[2]), 32'd0);
      chk("sim_w3", 32'(g_id[3]), 32'd1);
      chk("sim_gap", 32'(g_cyc[1] - g_cyc[0]), 32'd3);
    end else chk("sim_ngnt", 32'(g_id.size()), 32'd4);

    // misaligned access from requester 1
    clear_logs();
    do_req(1, 0, 5'd6, 32'h3);
    idle(3);
    chk("mis_nstrobe", 32'(s_cyc.size()), 32'd0);
    if (d_cyc.size() == 1 && g_cyc.size() == 1) begin
      chk("mis_gnt_id", 32'(g_id[0]), 32'd1);
      chk("mis_done_id", 32'(d_id[0]), 32'd1);
      chk("mis_done_lat", 32'(d_cyc[0] - g_cyc[0]), 32'd1);
      chk1("mis_err", d_err[0], 1'b1);
      chk("mis_rdata", d_rd[0], 32'd0);
    end else chk("mis_ndone", 32'(d_cyc.size()), 32'd1);

    // out of range 29, then 28 write and read
    clear_logs();
    do_req(0, 1, 5'd29, 32'h4);
    idle(3);
    do_req(0, 1, 5'd28, 32'hCAFEF00D);
    idle(3);
    do_req(0, 0, 5'd28, 32'h5);
    idle(3);
    if (d_cyc.size() == 3 && s_addr.size() == 2) begin
      chk1("oor_err", d_err[0], 1'b1);
      chk1("a28_err", d_err[1], 1'b0);
      chk("a28_addr", s_addr[0], 32'd28);
      chk("a28_rdata", d_rd[2], 32'hCAFEF00D);
    end else chk("oor_ndone", 32'(d_cyc.size()), 32'd3);

    // reset while a write to 4 is in ACCESS
    clear_logs();
    req0_i = 1; we0_i = 1; addr0_i = 5'd4; wdata0_i = 32'h55AA55AA;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_i);
      got = gnt0_o;
    end
    chk1("mid_grant_seen", got, 1'b1);
    @(posedge clk_i);
    #1;
    req0_i = 0;
    chk1("mid_strobe_on", mem_write_o, 1'b1);
    #2;
    reset_n = 0;
    #1;
    chk1("mid_strobe_cut", mem_write_o, 1'b0);
    chk("mid_addr_cut", mem_addr_o, 32'd0);
    idle(2);
    reset_n = 1;
    idle(2);
    chk("mid_ndone", 32'(d_cyc.size()), 32'd0);
    chk("mid_rdata_zero", rdata_o, 32'd0);
    do_req(0, 0, 5'd4, 32'h6);
    idle(3);
    if (d_cyc.size() == 1) begin
      chk("mid_reread", d_rd[0], 32'd0);
      chk("mid_ngnt", 32'(g_cyc.size()), 32'd2);
    end else chk("mid_after_done", 32'(d_cyc.size()), 32'd1);

    // back-to-back, req0 held across its done
    clear_logs();
    req0_i = 1; we0_i = 0; addr0_i = 5'd12;
    idle(4);
    req0_i = 0;
    idle(4);
    if (g_cyc.size() == 2 && d_cyc.size() == 2) begin
      chk("b2b_regrant", 32'(g_cyc[1] - d_cyc[0]), 32'd1);
      chk("b2b_id", 32'(g_id[1]), 32'd0);
    end else chk("b2b_ngnt", 32'(g_cyc.size()), 32'd2);

    // req0 held, req1 arrives: slot after done0 goes to 1
    clear_logs();
    req0_i = 1; addr0_i = 5'd12;
    idle(1);
    req1_i = 1; we1_i = 0; addr1_i = 5'd20;
    idle(3);
    req1_i = 0;
    idle(3);
    req0_i = 0;
    idle(4);
    if (g_id.size() == 3) begin
      chk("rr_w0", 32'(g_id[0]), 32'd0);
      chk("rr_w1", 32'(g_id[1]), 32'd1);
      chk("rr_w2", 32'(g_id[2]), 32'd0);
      chk("rr_gap", 32'(g_cyc[1] - g_cyc[0]), 32'd3);
    end else chk("rr_ngnt", 32'(g_id.size()), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
